tlul_rr_arbiter: RTL

// - N-master to 1-slave TL-UL arbiter. Round-robin arbitration on the A channel, source-indexed routing on the D channel.
// - Sits between master ports and the single slave port of tlul_interconnect_top, in the clk_100 domain.
// - Tracks outstanding requests per master and blocks any master that has reached its limit.

---
 rtl/tlul_rr_arbiter.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tlul_rr_arbiter.sv
// N-master to 1-slave TL-UL arbiter: round-robin A-channel grant, per-master outstanding limit,
// source-indexed D routing. Define TLUL_ARB_GNT_CNT_EN to add per-master grant counters (grant_cnt).
module tlul_rr_arbiter #(
    parameter int NUM_MASTERS     = 3,
    parameter int OPCODE_WIDTH    = 3,
    parameter int PARAM_WIDTH     = 3,
    parameter int SIZE_WIDTH      = 3,
    parameter int SRC_WIDTH       = 2,
    parameter int SINK_WIDTH      = 1,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int MASK_WIDTH      = DATA_WIDTH / 8
) (
    input  logic                                clk_100,
    input  logic                                reset,
    input  logic [NUM_MASTERS-1:0]              master_a_valid,
    output logic [NUM_MASTERS-1:0]              master_a_ready,
    input  logic [NUM_MASTERS*OPCODE_WIDTH-1:0] master_a_opcode,
    input  logic [NUM_MASTERS*PARAM_WIDTH-1:0]  master_a_param,
    input  logic [NUM_MASTERS*SIZE_WIDTH-1:0]   master_a_size,
    input  logic [NUM_MASTERS*SRC_WIDTH-1:0]    master_a_source,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   master_a_address,
    input  logic [NUM_MASTERS*MASK_WIDTH-1:0]   master_a_mask,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   master_a_data,
    output logic [NUM_MASTERS-1:0]              master_d_valid,
    input  logic [NUM_MASTERS-1:0]              master_d_ready,
    output logic [NUM_MASTERS*OPCODE_WIDTH-1:0] master_d_opcode,
    output logic [NUM_MASTERS*PARAM_WIDTH-1:0]  master_d_param,
    output logic [NUM_MASTERS*SIZE_WIDTH-1:0]   master_d_size,
    output logic [NUM_MASTERS*SRC_WIDTH-1:0]    master_d_source,
    output logic [NUM_MASTERS*SINK_WIDTH-1:0]   master_d_sink,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0]   master_d_data,
    output logic [NUM_MASTERS-1:0]              master_d_error,
    output logic                                slave_a_valid,
    input  logic                                slave_a_ready,
    output logic [OPCODE_WIDTH-1:0]             slave_a_opcode,
    output logic [PARAM_WIDTH-1:0]              slave_a_param,
    output logic [SIZE_WIDTH-1:0]               slave_a_size,
    output logic [SRC_WIDTH-1:0]                slave_a_source,
    output logic [ADDR_WIDTH-1:0]               slave_a_address,
    output logic [MASK_WIDTH-1:0]               slave_a_mask,
    output logic [DATA_WIDTH-1:0]               slave_a_data,
    input  logic                                slave_d_valid,
    output logic                                slave_d_ready,
    input  logic [OPCODE_WIDTH-1:0]             slave_d_opcode,
    input  logic [PARAM_WIDTH-1:0]              slave_d_param,
    input  logic [SIZE_WIDTH-1:0]               slave_d_size,
    input  logic [SRC_WIDTH-1:0]                slave_d_source,
    input  logic [SINK_WIDTH-1:0]               slave_d_sink,
    input  logic [DATA_WIDTH-1:0]               slave_d_data,
    input  logic                                slave_d_error,
    output logic                                route_err
`ifdef TLUL_ARB_GNT_CNT_EN
    ,
    output logic [NUM_MASTERS*16-1:0]           grant_cnt
`endif
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [SRC_WIDTH:0] NUM_M_EXT = (SRC_WIDTH + 1)'(NUM_MASTERS);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_e;

    state_e                 state_q, state_d;
    logic [SRC_WIDTH-1:0]   grant_q, grant_d;
    logic [SRC_WIDTH-1:0]   last_q, last_d;
    logic [CW-1:0]          out_cnt_q [NUM_MASTERS];
    logic [CW-1:0]          out_cnt_d [NUM_MASTERS];
    logic                   route_err_q, route_err_d;

    logic [NUM_MASTERS-1:0] eligible_s;
    logic [NUM_MASTERS-1:0] gsel_s;
    logic [NUM_MASTERS-1:0] d_sel_s;
    logic [NUM_MASTERS-1:0] d_dec_s;
    logic [SRC_WIDTH-1:0]   pick_idx_s;
    logic                   pick_found_s;
    logic                   sel_valid_s;
    logic                   a_hs_s;
    logic                   d_idx_ok_s;
    logic                   unused_src_s;

    // The requester's own source id is replaced by its port index.
    assign unused_src_s = ^master_a_source;

    // Eligibility: requesting and below the in-flight limit.
    always_comb begin
        eligible_s = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            eligible_s[i] = master_a_valid[i] && (out_cnt_q[i] < CW'(MAX_OUTSTANDING));
        end
    end

    // Round-robin pick: first eligible index after the last granted one, with wrap.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            for (int j = 0; j < NUM_MASTERS; j++) begin
                pick_idx_s   = (!pick_found_s && eligible_s[j] && (((int'(last_q) + k) % NUM_MASTERS) == j))
                               ? SRC_WIDTH'(j) : pick_idx_s;
                pick_found_s = pick_found_s |
                               (eligible_s[j] && (((int'(last_q) + k) % NUM_MASTERS) == j));
            end
        end
    end

    // A-channel mux from the granted master; grant is one-hot so OR-reduction selects it.
    always_comb begin
        gsel_s          = '0;
        sel_valid_s     = 1'b0;
        slave_a_opcode  = '0;
        slave_a_param   = '0;
        slave_a_size    = '0;
        slave_a_address = '0;
        slave_a_mask    = '0;
        slave_a_data    = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            gsel_s[i]       = (grant_q == SRC_WIDTH'(i));
            sel_valid_s     = sel_valid_s | (gsel_s[i] & master_a_valid[i]);
            slave_a_opcode  = slave_a_opcode  | ({OPCODE_WIDTH{gsel_s[i]}} & master_a_opcode[i*OPCODE_WIDTH +: OPCODE_WIDTH]);
            slave_a_param   = slave_a_param   | ({PARAM_WIDTH{gsel_s[i]}}  & master_a_param[i*PARAM_WIDTH +: PARAM_WIDTH]);
            slave_a_size    = slave_a_size    | ({SIZE_WIDTH{gsel_s[i]}}   & master_a_size[i*SIZE_WIDTH +: SIZE_WIDTH]);
            slave_a_address = slave_a_address | ({ADDR_WIDTH{gsel_s[i]}}   & master_a_address[i*ADDR_WIDTH +: ADDR_WIDTH]);
            slave_a_mask    = slave_a_mask    | ({MASK_WIDTH{gsel_s[i]}}   & master_a_mask[i*MASK_WIDTH +: MASK_WIDTH]);
            slave_a_data    = slave_a_data    | ({DATA_WIDTH{gsel_s[i]}}   & master_a_data[i*DATA_WIDTH +: DATA_WIDTH]);
        end
        slave_a_source = grant_q;
        slave_a_valid  = (state_q == ST_GRANT) && sel_valid_s;
        master_a_ready = gsel_s & {NUM_MASTERS{(state_q == ST_GRANT) && slave_a_ready}};
        a_hs_s         = slave_a_valid && slave_a_ready;
    end

    // D routing by source; out-of-range sources are acknowledged and dropped.
    always_comb begin
        d_sel_s    = '0;
        d_idx_ok_s = ({1'b0, slave_d_source} < NUM_M_EXT);
        for (int i = 0; i < NUM_MASTERS; i++) begin
            d_sel_s[i] = d_idx_ok_s && (slave_d_source == SRC_WIDTH'(i));
        end
        master_d_valid = d_sel_s & {NUM_MASTERS{slave_d_valid}};
        slave_d_ready  = d_idx_ok_s ? |(d_sel_s & master_d_ready) : 1'b1;
        d_dec_s        = d_sel_s & {NUM_MASTERS{slave_d_valid && slave_d_ready}};
    end

    assign master_d_opcode = {NUM_MASTERS{slave_d_opcode}};
    assign master_d_param  = {NUM_MASTERS{slave_d_param}};
    assign master_d_size   = {NUM_MASTERS{slave_d_size}};
    assign master_d_source = {NUM_MASTERS{slave_d_source}};
    assign master_d_sink   = {NUM_MASTERS{slave_d_sink}};
    assign master_d_data   = {NUM_MASTERS{slave_d_data}};
    assign master_d_error  = {NUM_MASTERS{slave_d_error}};
    assign route_err       = route_err_q;

    // Arbitration FSM next state; grant stays put until its handshake completes.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_d = ST_GRANT;
                    grant_d = pick_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (a_hs_s) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outstanding counters: A handshake adds, D handshake removes, both cancel, floor at zero.
    always_comb begin
        route_err_d = route_err_q | (slave_d_valid && !d_idx_ok_s);
        for (int i = 0; i < NUM_MASTERS; i++) begin
            case ({a_hs_s && gsel_s[i], d_dec_s[i]})
                2'b10:   out_cnt_d[i] = out_cnt_q[i] + CW'(1);
                2'b01:   out_cnt_d[i] = (out_cnt_q[i] == '0) ? '0 : out_cnt_q[i] - CW'(1);
                default: out_cnt_d[i] = out_cnt_q[i];
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            last_q      <= SRC_WIDTH'(NUM_MASTERS - 1);
            route_err_q <= 1'b0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                out_cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            route_err_q <= route_err_d;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                out_cnt_q[i] <= out_cnt_d[i];
            end
        end
    end

`ifdef TLUL_ARB_GNT_CNT_EN
    logic [15:0] gnt_cnt_q [NUM_MASTERS];
    logic [15:0] gnt_cnt_d [NUM_MASTERS];

    // Per-master accepted-request counters, free-running with natural wrap.
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            gnt_cnt_d[i]          = gnt_cnt_q[i] + 16'(a_hs_s && gsel_s[i]);
            grant_cnt[i*16 +: 16] = gnt_cnt_q[i];
        end
    end

    // Grant counter registers.
    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                gnt_cnt_q[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                gnt_cnt_q[i] <= gnt_cnt_d[i];
            end
        end
    end
`endif

endmodule
